// File: rtl/local_bias_buffer.sv
// Bias store for one convolution layer: single-word writes, burst loads, sequential clear, registered reads.
// Optional macro BIAS_RAW_FWD_EN: a same-cycle read of the address being written returns the new data.
module local_bias_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 10,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  input  logic              clr_start,
  output logic              busy,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err
);

  // Load handshake: a beat transfers on any rising edge where ld_valid && ld_ready;
  // ld_valid may drop at any time (stall), ld_ready is high for the whole LOAD state.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic                done_q, done_d;

  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   wdata;
  logic [ADDR_W:0]     len_eff;
  logic [ADDR_W-1:0]   base_eff;
  logic [ADDR_W-1:0]   ptr_next;
  logic                wr_ok;
  logic                rd_ok;
  logic [ADDR_W-1:0]   rd_idx;
  logic                fwd_hit;

  logic [DATA_W-1:0]   mem [DEPTH];

  assign wr_ok    = ({1'b0, wr_addr} < DEPTH_C);
  assign rd_ok    = ({1'b0, rd_addr} < DEPTH_C);
  assign rd_idx   = rd_ok ? rd_addr : '0;
  assign ptr_next = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    done_d   = 1'b0;
    we       = 1'b0;
    waddr    = ptr_q;
    wdata    = '0;
    len_eff  = (ld_len > DEPTH_C) ? DEPTH_C : ld_len;
    base_eff = ({1'b0, ld_base} >= DEPTH_C) ? '0 : ld_base;
    unique case (state_q)
      IDLE: begin
        // Priority ld_start > clr_start > wr_en; the losers are simply dropped.
        if (ld_start) begin
          if (len_eff == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = LOAD;
            ptr_d   = base_eff;
            cnt_d   = '0;
            len_d   = len_eff;
          end
        end else if (clr_start) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end else if (wr_en && wr_ok) begin
          we    = 1'b1;
          waddr = wr_addr;
          wdata = wr_data;
        end
      end
      LOAD: begin
        if (ld_valid) begin
          we    = 1'b1;
          waddr = ptr_q;
          wdata = ld_data;
          ptr_d = ptr_next;
          cnt_d = cnt_q + 1'b1;
          if ((cnt_q + 1'b1) == len_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      CLEAR: begin
        we    = 1'b1;
        waddr = ptr_q;
        wdata = '0;
        ptr_d = ptr_next;
        if (ptr_q == LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ld_ready = (state_q == LOAD);
  assign busy     = (state_q != IDLE);
  assign ld_done  = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

`ifdef BIAS_RAW_FWD_EN
  assign fwd_hit = we && (waddr == rd_addr);
`else
  assign fwd_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_err   <= rd_en && !rd_ok;
      if (rd_en && rd_ok) rd_data <= fwd_hit ? wdata : mem[rd_idx];
      else                rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_local_bias_buffer.sv
// Directed bench for local_bias_buffer (DATA_W=16, DEPTH=10).
module tb_local_bias_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        ld_start;
  logic [3:0]  ld_base;
  logic [4:0]  ld_len;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_ready;
  logic        ld_done;
  logic        clr_start;
  logic        busy;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_err;

  int n_checks = 0;
  int n_fail   = 0;

  local_bias_buffer dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready), .ld_done(ld_done),
    .clr_start(clr_start), .busy(busy),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [3:0] addr, input logic [15:0] exp_data, input logic exp_err,
                         input string tag);
    rd_en   = 1'b1;
    rd_addr = addr;
    tick();
    rd_en = 1'b0;
    chk({tag, "_data"}, 32'(rd_data), 32'(exp_data));
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, "_err"}, 32'(rd_err), 32'(exp_err));
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [15:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    int acc;
    int n;
    logic done_seen;

    rst = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0;
    ld_start = 0; ld_base = 0; ld_len = 0; ld_valid = 0; ld_data = 0;
    clr_start = 0; rd_en = 0; rd_addr = 0;

    // Reset state
    tick(); tick();
    chk("rst_ld_ready", 32'(ld_ready), 0);
    chk("rst_ld_done", 32'(ld_done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_err", 32'(rd_err), 0);
    rst = 1'b0;
    tick();

    // Back-to-back reads of a cleared memory
    rd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rd_addr = 4'(i);
      tick();
      chk($sformatf("init_rd%0d_data", i), 32'(rd_data), 0);
      chk($sformatf("init_rd%0d_valid", i), 32'(rd_valid), 1);
      chk($sformatf("init_rd%0d_err", i), 32'(rd_err), 0);
    end
    rd_en = 1'b0;
    tick();
    chk("idle_rd_valid", 32'(rd_valid), 0);

    // Single write, read back, out-of-range read, out-of-range write ignored
    do_write(4'd3, 16'h1234);
    do_read(4'd3, 16'h1234, 1'b0, "wr3");
    do_read(4'd12, 16'h0000, 1'b1, "oor12");
    do_write(4'd11, 16'hDEAD);
    do_read(4'd1, 16'h0000, 1'b0, "oor_wr_ignored");

    // Burst load base 8 len 4 with a stall on the second cycle
    ld_start = 1'b1; ld_base = 4'd8; ld_len = 5'd4;
    tick();
    ld_start = 1'b0;
    chk("ld_busy_start", 32'(busy), 1);
    chk("ld_ready_start", 32'(ld_ready), 1);
    ld_valid = 1'b1; ld_data = 16'h00A0; tick();
    chk("ld_done_b0", 32'(ld_done), 0);
    ld_valid = 1'b0; tick();
    chk("ld_busy_stall", 32'(busy), 1);
    chk("ld_done_stall", 32'(ld_done), 0);
    ld_valid = 1'b1; ld_data = 16'h00A1; tick();
    ld_data = 16'h00A2; tick();
    chk("ld_done_b2", 32'(ld_done), 0);
    chk("ld_busy_b2", 32'(busy), 1);
    ld_data = 16'h00A3; tick();
    ld_valid = 1'b0;
    chk("ld_done_pulse", 32'(ld_done), 1);
    chk("ld_busy_end", 32'(busy), 0);
    chk("ld_ready_end", 32'(ld_ready), 0);
    tick();
    chk("ld_done_once", 32'(ld_done), 0);
    do_read(4'd8, 16'h00A0, 1'b0, "ld_e8");
    do_read(4'd9, 16'h00A1, 1'b0, "ld_e9");
    do_read(4'd0, 16'h00A2, 1'b0, "ld_e0");
    do_read(4'd1, 16'h00A3, 1'b0, "ld_e1");
    do_read(4'd3, 16'h1234, 1'b0, "ld_e3_kept");

    // Zero-length load
    ld_start = 1'b1; ld_base = 4'd2; ld_len = 5'd0;
    tick();
    ld_start = 1'b0;
    chk("len0_done", 32'(ld_done), 1);
    chk("len0_busy", 32'(busy), 0);
    tick();
    chk("len0_done_once", 32'(ld_done), 0);

    // Oversized load is clamped to DEPTH beats
    ld_start = 1'b1; ld_base = 4'd0; ld_len = 5'd15;
    tick();
    ld_start = 1'b0;
    acc = 0; done_seen = 1'b0;
    ld_valid = 1'b1;
    for (int i = 0; i < 20 && !done_seen; i++) begin
      ld_data = 16'(16'h0100 + acc);
      if (ld_ready) acc++;
      tick();
      if (ld_done) done_seen = 1'b1;
    end
    ld_valid = 1'b0;
    chk("len15_done_seen", 32'(done_seen), 1);
    chk("len15_beats", 32'(acc), 10);
    do_read(4'd0, 16'h0100, 1'b0, "len15_e0");
    do_read(4'd9, 16'h0109, 1'b0, "len15_e9");

    // Preload 0xFFFF then clear; wr_en held during CLEAR must be ignored
    for (int i = 0; i < 10; i++) do_write(4'(i), 16'hFFFF);
    do_read(4'd4, 16'hFFFF, 1'b0, "pre_e4");
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'hBEEF;
    n = 0;
    while (busy && n < 20) begin
      n++;
      tick();
    end
    wr_en = 1'b0;
    chk("clr_busy_cycles", 32'(n), 10);
    for (int i = 0; i < 10; i++) do_read(4'(i), 16'h0000, 1'b0, $sformatf("clr_e%0d", i));

    // Same-cycle read and write of one address
    do_write(4'd5, 16'h0001);
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h0002;
    rd_en = 1'b1; rd_addr = 4'd5;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
`ifdef BIAS_RAW_FWD_EN
    chk("raw_data", 32'(rd_data), 32'h0002);
`else
    chk("raw_data", 32'(rd_data), 32'h0001);
`endif
    chk("raw_valid", 32'(rd_valid), 1);
    do_read(4'd5, 16'h0002, 1'b0, "raw_after");

    // Reset in the middle of a load
    ld_start = 1'b1; ld_base = 4'd0; ld_len = 5'd4;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 16'h00CC; rd_en = 1'b1; rd_addr = 4'd5;
    tick();
    ld_valid = 1'b0; rd_en = 1'b0;
    chk("mid_busy", 32'(busy), 1);
    chk("mid_rd_valid", 32'(rd_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_ld_ready", 32'(ld_ready), 0);
    chk("arst_ld_done", 32'(ld_done), 0);
    chk("arst_rd_data", 32'(rd_data), 0);
    chk("arst_rd_valid", 32'(rd_valid), 0);
    chk("arst_rd_err", 32'(rd_err), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("arst_no_done", 32'(ld_done), 0);
    do_read(4'd0, 16'h0000, 1'b0, "arst_e0");
    do_read(4'd5, 16'h0000, 1'b0, "arst_e5");
    chk("arst_idle_busy", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
